vga_layer_compositor: RTL and testbench
=======================================

# vga_layer_compositor

Parametrised VGA raster engine: one timing generator plus an N-layer rectangle compositor with a registered output pipeline. It sits between the game control logic, which supplies per-layer rectangle geometry and colour, and the board VGA pins. It generalises the fixed 800x600@72 Hz, three-rectangle, 1-bit-colour renderer. New behaviour: configurable timing, sync polarity, layer count and colour depth, plus frame-coherent (shadowed) geometry updates.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal porch and sync widths (total 1040)
- V_ACTIVE, 600, visible lines
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical porch and sync widths (total 666)
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- NUM_LAYERS, 4, rectangle layers, 1..16
- COLOR_W, 4, bits per colour channel
- COORD_W, 11, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- layer_en  in  NUM_LAYERS  per-layer enable
- layer_hfrom, layer_hto, layer_vfrom, layer_vto  in  NUM_LAYERS*COORD_W each  inclusive bounds, layer i in slice i
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer colour {R,G,B} per slice
- bg_rgb  in  3*COLOR_W  background colour
- vga_r, vga_g, vga_b  out  COLOR_W each  pixel colour
- vga_hs, vga_vs  out  1  sync outputs
- vga_de  out  1  active-video flag, aligned with colour
- hcount, vcount  out  COORD_W each  stage-0 raster position
- frame_start  out  1  one-cycle pulse when hcount=0 and vcount=0

## Operation
- hcount runs 0..H_TOTAL-1 and wraps to 0. vcount increments when hcount wraps and runs 0..V_TOTAL-1, then wraps to 0.
- HS is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 856..975 by default. VS is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 637..642. Asserted level is the corresponding _POL value.
- Active video is hcount<H_ACTIVE and vcount<V_ACTIVE.
- Shadow registers hold all layer inputs. They load when hcount=H_TOTAL-1 and vcount=V_ACTIVE-1, i.e. at the end of the last visible line. Input changes at any other time have no visible effect until the next load, so there is no tearing.
- A layer hits when it is enabled in shadow, hfrom≤hcount≤hto and vfrom≤vcount≤vto. If from>to on either axis, the layer never hits.
- Priority: the lowest hitting index wins. With no hit, the output is bg_rgb, and bg_rgb is not shadowed. Outside active video, colour is forced to 0.

## Timing
- Stage 0 holds the counters. Stage 1 registers the per-layer hit vector, the sync compares and the active flag. Stage 2 registers the priority-muxed colour, vga_hs, vga_vs and vga_de.
- Colour, sync and DE for raster position (h,v) appear exactly 2 cycles after hcount/vcount show (h,v). All pin outputs are mutually aligned.
- frame_start is combinational from stage 0 and is not delayed.
- Reset (async, mid-frame included) clears all of the following:
  - counters to 0
  - shadow layer_en to 0 and shadow bounds to 0
  - pipeline registers, so colour outputs are 0 and vga_de is 0
  - vga_hs to ~HS_POL and vga_vs to ~VS_POL
- The first shadow load after reset happens at line V_ACTIVE-1. Until then only the background shows.

## Configuration
- VGA_TEST_PATTERN_EN: when defined, adds input test_mode (1 bit), which goes through the same shadow register.
  - With shadowed test_mode=1, layers are ignored and active video shows 8 vertical bars, each H_ACTIVE/8 wide. Bar k has R=k[2], G=k[1], B=k[0] replicated to COLOR_W bits.
  - When the macro is undefined, the port and logic are absent.

## Structure
- Package vga_pkg holds:
  - the default timing localparams (800x600@72)
  - a rgb_t struct {r,g,b}
  - a helper function for the sync-window compare
- Sub-module vga_timing_gen contains the counters, sync compare, active flag and frame_start. The compositor instantiates it and adds the shadow registers and the pipeline.

## Test plan
- Reset behaviour: assert rst for 5 cycles → vga_de=0, colour=0, vga_hs=vga_vs=1 with active-low sync, hcount=vcount=0.
- Sync timing at defaults: HS period is 1040 clocks with 120 asserted cycles, first asserted 2 cycles after hcount=856. VS period is 666 lines with 6 asserted lines.
- Layer priority: layer0 is (100..199,100..199) red F00 and layer1 is (150..249,150..249) green 0F0. At (160,160) the output is F00, at (220,220) it is 0F0, and at (50,50) it is bg_rgb.
- Shadow coherence: change layer0 bounds during line 300 → output is unchanged for the rest of the frame, and the new geometry appears from line 0 of the next frame.
- Boundary cases: layer with hfrom=300, hto=299 → it never hits. Rectangle edge pixels at hfrom and hto are included. Colour is 0 at hcount ≥ 800.
- With the macro defined: test_mode=1 → pixel 0 is 000, pixel 100 is 00F and pixel 700 is FFF on the next frame.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA layer compositor.
// Default 800x600@72 timing, the rgb_t pixel struct and the sync-window
// compare used by the timing generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 56;
  localparam int H_SYNC_DEF   = 120;
  localparam int H_BP_DEF     = 64;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 37;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 23;

  // Widest colour channel the compositor supports; narrower channels sit in
  // the low bits of each field.
  localparam int RGB_MAX_W = 8;

  typedef struct packed {
    logic [RGB_MAX_W-1:0] r;
    logic [RGB_MAX_W-1:0] g;
    logic [RGB_MAX_W-1:0] b;
  } rgb_t;

  // True when pos lies in the window [lo, lo+len-1].
  function automatic logic in_window(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters (stage 0) for the VGA compositor.
// Produces hcount/vcount, asserted-sync flags, the active-video flag, the
// frame_start pulse and the shadow-load strobe at the end of the last
// visible line. All decode outputs are combinational from the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int COORD_W  = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [COORD_W-1:0] hcount_o,
  output logic [COORD_W-1:0] vcount_o,
  output logic               hs_on_o,
  output logic               vs_on_o,
  output logic               active_o,
  output logic               frame_start_o,
  output logic               shadow_load_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_LOAD  = COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] hcount_q, hcount_d;
  logic [COORD_W-1:0] vcount_q, vcount_d;
  logic               line_end;

  assign line_end = (hcount_q == H_LAST);

  // Next raster position: h wraps every line, v advances on each h wrap.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (line_end) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
  end

  // Stage 0: raster counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hs_on_o       = in_window(int'(hcount_q), H_ACTIVE + H_FP, H_SYNC);
  assign vs_on_o       = in_window(int'(vcount_q), V_ACTIVE + V_FP, V_SYNC);
  assign active_o      = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
  assign frame_start_o = (hcount_q == '0) && (vcount_q == '0);
  // Last pixel of the last visible line: geometry swaps during blanking.
  assign shadow_load_o = line_end && (vcount_q == V_LOAD);

endmodule

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: VGA raster engine with an N-layer rectangle
// compositor. Layer geometry/colour is captured into shadow registers at the
// end of the last visible line so updates never tear mid-frame.
// Pipeline: stage 0 counters, stage 1 hit vector + sync/active, stage 2
// priority-muxed colour and sync pins (2-cycle latency from hcount/vcount).
// Optional: define VGA_TEST_PATTERN_EN to add the test_mode input, which
// replaces the layers with 8 vertical colour bars.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4,
  parameter int COORD_W    = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_hfrom,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_hto,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_vfrom,
  input  logic [NUM_LAYERS*COORD_W-1:0]   layer_vto,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                            test_mode,
`endif
  output logic [COLOR_W-1:0]              vga_r,
  output logic [COLOR_W-1:0]              vga_g,
  output logic [COLOR_W-1:0]              vga_b,
  output logic                            vga_hs,
  output logic                            vga_vs,
  output logic                            vga_de,
  output logic [COORD_W-1:0]              hcount,
  output logic [COORD_W-1:0]              vcount,
  output logic                            frame_start
);

  localparam int CW = NUM_LAYERS * COORD_W;
  localparam int RW = NUM_LAYERS * 3 * COLOR_W;

  // Split a packed {R,G,B} word into the wide pixel struct.
  function automatic rgb_t to_rgb(input logic [3*COLOR_W-1:0] v);
    rgb_t p;
    p.r = RGB_MAX_W'(v[3*COLOR_W-1 -: COLOR_W]);
    p.g = RGB_MAX_W'(v[2*COLOR_W-1 -: COLOR_W]);
    p.b = RGB_MAX_W'(v[COLOR_W-1 -: COLOR_W]);
    return p;
  endfunction

  // ---------------------------------------------------------------- stage 0
  logic [COORD_W-1:0] h_p0, v_p0;
  logic               hs_on_p0, vs_on_p0, active_p0, load_p0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .COORD_W  (COORD_W)
  ) u_timing (
    .clk_i         (clk),
    .rst_i         (rst),
    .hcount_o      (h_p0),
    .vcount_o      (v_p0),
    .hs_on_o       (hs_on_p0),
    .vs_on_o       (vs_on_p0),
    .active_o      (active_p0),
    .frame_start_o (frame_start),
    .shadow_load_o (load_p0)
  );

  assign hcount = h_p0;
  assign vcount = v_p0;

  // Shadow copies of the layer inputs, the only geometry the raster sees.
  logic [NUM_LAYERS-1:0] en_q;
  logic [CW-1:0]         hfrom_q, hto_q, vfrom_q, vto_q;
  logic [RW-1:0]         rgb_q;
`ifdef VGA_TEST_PATTERN_EN
  logic                  test_q;
`endif

  // Capture layer inputs once per frame, during vertical blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= '0;
      hfrom_q <= '0;
      hto_q   <= '0;
      vfrom_q <= '0;
      vto_q   <= '0;
      rgb_q   <= '0;
`ifdef VGA_TEST_PATTERN_EN
      test_q  <= 1'b0;
`endif
    end else if (load_p0) begin
      en_q    <= layer_en;
      hfrom_q <= layer_hfrom;
      hto_q   <= layer_hto;
      vfrom_q <= layer_vfrom;
      vto_q   <= layer_vto;
      rgb_q   <= layer_rgb;
`ifdef VGA_TEST_PATTERN_EN
      test_q  <= test_mode;
`endif
    end
  end

  // Per-layer hit test; from>to on either axis can never satisfy both bounds.
  logic [NUM_LAYERS-1:0] hit_d;
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      hit_d[i] = en_q[i]
               && (hfrom_q[i*COORD_W +: COORD_W] <= h_p0)
               && (h_p0 <= hto_q[i*COORD_W +: COORD_W])
               && (vfrom_q[i*COORD_W +: COORD_W] <= v_p0)
               && (v_p0 <= vto_q[i*COORD_W +: COORD_W]);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0] bar_d;
  assign bar_d = 3'(int'(h_p0) / BAR_W);
`endif

  // ---------------------------------------------------------------- stage 1
  logic [NUM_LAYERS-1:0] hit_p1_q;
  logic                  hs_p1_q, vs_p1_q, de_p1_q;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]            bar_p1_q;
`endif

  // Register hit vector, sync levels and active flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1_q <= '0;
      hs_p1_q  <= ~HS_POL;
      vs_p1_q  <= ~VS_POL;
      de_p1_q  <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      bar_p1_q <= '0;
`endif
    end else begin
      hit_p1_q <= hit_d;
      hs_p1_q  <= hs_on_p0 ? HS_POL : ~HS_POL;
      vs_p1_q  <= vs_on_p0 ? VS_POL : ~VS_POL;
      de_p1_q  <= active_p0;
`ifdef VGA_TEST_PATTERN_EN
      bar_p1_q <= bar_d;
`endif
    end
  end

  // Priority mux: lowest hitting index wins, background otherwise, black in blanking.
  rgb_t pix_d;
  logic pix_unused;
  always_comb begin
    pix_d = to_rgb(bg_rgb);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_p1_q[i]) begin
        pix_d = to_rgb(rgb_q[i*3*COLOR_W +: 3*COLOR_W]);
      end
    end
`ifdef VGA_TEST_PATTERN_EN
    if (test_q) begin
      pix_d.r = RGB_MAX_W'({COLOR_W{bar_p1_q[2]}});
      pix_d.g = RGB_MAX_W'({COLOR_W{bar_p1_q[1]}});
      pix_d.b = RGB_MAX_W'({COLOR_W{bar_p1_q[0]}});
    end
`endif
    if (!de_p1_q) begin
      pix_d = '0;
    end
  end

  // Bits above COLOR_W are always zero and intentionally dropped.
  assign pix_unused = ^pix_d;

  // ---------------------------------------------------------------- stage 2
  logic [COLOR_W-1:0] r_p2_q, g_p2_q, b_p2_q;
  logic               hs_p2_q, vs_p2_q, de_p2_q;

  // Register the pin outputs so colour, sync and DE stay mutually aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2_q  <= '0;
      g_p2_q  <= '0;
      b_p2_q  <= '0;
      hs_p2_q <= ~HS_POL;
      vs_p2_q <= ~VS_POL;
      de_p2_q <= 1'b0;
    end else begin
      r_p2_q  <= pix_d.r[COLOR_W-1:0];
      g_p2_q  <= pix_d.g[COLOR_W-1:0];
      b_p2_q  <= pix_d.b[COLOR_W-1:0];
      hs_p2_q <= hs_p1_q;
      vs_p2_q <= vs_p1_q;
      de_p2_q <= de_p1_q;
    end
  end

  assign vga_r  = r_p2_q;
  assign vga_g  = g_p2_q;
  assign vga_b  = b_p2_q;
  assign vga_hs = hs_p2_q;
  assign vga_vs = vs_p2_q;
  assign vga_de = de_p2_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a reduced 80x56 raster
// (64x48 visible) so several frames fit in a short run.
module tb_vga_layer_compositor;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 3, VB = 3;
  localparam int NL = 4, CWD = 4, W = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NL-1:0]         layer_en;
  logic [NL*W-1:0]       layer_hfrom, layer_hto, layer_vfrom, layer_vto;
  logic [NL*3*CWD-1:0]   layer_rgb;
  logic [3*CWD-1:0]      bg_rgb;
  logic                  test_mode;
  logic [CWD-1:0]        vga_r, vga_g, vga_b;
  logic                  vga_hs, vga_vs, vga_de;
  logic [W-1:0]          hcount, vcount;
  logic                  frame_start;

  int checks = 0;
  int errors = 0;

  vga_layer_compositor #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .NUM_LAYERS (NL), .COLOR_W (CWD), .COORD_W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .layer_en    (layer_en),
    .layer_hfrom (layer_hfrom),
    .layer_hto   (layer_hto),
    .layer_vfrom (layer_vfrom),
    .layer_vto   (layer_vto),
    .layer_rgb   (layer_rgb),
    .bg_rgb      (bg_rgb),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_layer(input int i, input logic en, input int hf, input int ht,
                           input int vf, input int vt, input logic [11:0] rgb);
    layer_en[i]              = en;
    layer_hfrom[i*W +: W]    = W'(hf);
    layer_hto[i*W +: W]      = W'(ht);
    layer_vfrom[i*W +: W]    = W'(vf);
    layer_vto[i*W +: W]      = W'(vt);
    layer_rgb[i*12 +: 12]    = rgb;
  endtask

  // Advance (at falling edges) until stage 0 shows (h,v); bounded.
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(hcount == W'(h) && vcount == W'(v)) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk($sformatf("goto_%0d_%0d_timeout", h, v), 32'(n), 32'(0));
  endtask

  // Pin outputs for (h,v) appear two clocks after stage 0 shows it.
  task automatic check_pix(input int h, input int v, input logic [11:0] exp_rgb, input logic exp_de);
    goto(h, v);
    repeat (2) @(negedge clk);
    chk($sformatf("rgb_%0d_%0d", h, v), 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    chk($sformatf("de_%0d_%0d", h, v), 32'(vga_de), 32'(exp_de));
  endtask

  initial begin
    int lo, hi;
    rst         = 1'b1;
    test_mode   = 1'b0;
    layer_en    = '0;
    layer_hfrom = '0;
    layer_hto   = '0;
    layer_vfrom = '0;
    layer_vto   = '0;
    layer_rgb   = '0;
    bg_rgb      = 12'h123;
    set_layer(0, 1'b1, 10, 19, 10, 19, 12'hF00);
    set_layer(1, 1'b1, 15, 24, 15, 24, 12'h0F0);
    set_layer(2, 1'b1, 30, 29, 0, 47, 12'h00F);
    set_layer(3, 1'b1, 40, 45, 30, 35, 12'hFF0);

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_de", 32'(vga_de), 32'(0));
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
    chk("rst_hs", 32'(vga_hs), 32'(1));
    chk("rst_vs", 32'(vga_vs), 32'(1));
    chk("rst_hcount", 32'(hcount), 32'(0));
    chk("rst_vcount", 32'(vcount), 32'(0));
    rst = 1'b0;

    // Frame 0: shadow still cleared, only background visible
    check_pix(16, 16, 12'h123, 1'b1);

    // Horizontal sync on line 1: asserted from h=68 for 8 of 80 clocks
    goto(67, 1);
    repeat (2) @(negedge clk);
    chk("hs_before", 32'(vga_hs), 32'(1));
    @(negedge clk);
    chk("hs_first", 32'(vga_hs), 32'(0));
    lo = 0;
    while (vga_hs === 1'b0 && lo < 1000) begin lo++; @(negedge clk); end
    hi = 0;
    while (vga_hs === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
    chk("hs_width", 32'(lo), 32'(HS));
    chk("hs_period", 32'(lo + hi), 32'(80));

    // Vertical sync: lines 50..52 of 56
    goto(79, 49);
    repeat (2) @(negedge clk);
    chk("vs_before", 32'(vga_vs), 32'(1));
    @(negedge clk);
    chk("vs_first", 32'(vga_vs), 32'(0));
    lo = 0;
    while (vga_vs === 1'b0 && lo < 10000) begin lo++; @(negedge clk); end
    hi = 0;
    while (vga_vs === 1'b1 && hi < 10000) begin hi++; @(negedge clk); end
    chk("vs_width", 32'(lo), 32'(VS * 80));
    chk("vs_period", 32'(lo + hi), 32'(56 * 80));

    // Frame 2: layers loaded at end of frame 0 line 47
    check_pix(5, 5, 12'h123, 1'b1);
    check_pix(30, 5, 12'h123, 1'b1);
    check_pix(10, 10, 12'hF00, 1'b1);
    check_pix(12, 12, 12'hF00, 1'b1);
    check_pix(19, 12, 12'hF00, 1'b1);
    check_pix(20, 13, 12'h123, 1'b1);
    check_pix(16, 16, 12'hF00, 1'b1);
    check_pix(22, 22, 12'h0F0, 1'b1);
    check_pix(24, 24, 12'h0F0, 1'b1);
    // Move layer 0 mid-frame; must not show until next frame
    goto(0, 25);
    set_layer(0, 1'b1, 0, 5, 30, 40, 12'hF00);
    check_pix(40, 30, 12'hFF0, 1'b1);
    check_pix(2, 32, 12'h123, 1'b1);
    check_pix(45, 35, 12'hFF0, 1'b1);
    check_pix(46, 34, 12'h123, 1'b1);
    check_pix(64, 36, 12'h000, 1'b0);
    check_pix(70, 40, 12'h000, 1'b0);

    // frame_start is a one-cycle stage-0 pulse
    goto(0, 0);
    chk("frame_start_hi", 32'(frame_start), 32'(1));
    @(negedge clk);
    chk("frame_start_lo", 32'(frame_start), 32'(0));

    // Frame 3: new layer 0 geometry in effect
    check_pix(12, 12, 12'h123, 1'b1);
    check_pix(2, 32, 12'hF00, 1'b1);
    check_pix(3, 40, 12'hF00, 1'b1);
    check_pix(6, 35, 12'h123, 1'b1);

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    check_pix(10, 44, 12'h123, 1'b1);
    check_pix(0, 5, 12'h000, 1'b1);
    check_pix(10, 5, 12'h00F, 1'b1);
    check_pix(20, 5, 12'h0F0, 1'b1);
    check_pix(60, 5, 12'hFFF, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
